// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: drives a W-bit latch bank's D/enable with a setup, pulse, hold sequence
// Ports:
//   Clk       rising-edge clock
//   reset     synchronous active-high reset
//   data_in   word to write, captured on handshake
//   valid_in  producer has a word
//   ready_out high only in IDLE
//   D         registered data to the latch bank
//   enable    registered latch enable, high only in PULSE
//   busy      high in any state other than IDLE
//   done      one-cycle pulse in the first IDLE cycle after a write
module latch_write_sequencer #(
  parameter int W         = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [W-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [W-1:0] D,
  output logic         enable,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  // Counter reload values: a state lasting N cycles starts at N-1 and exits at 0.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC > 0 ? SETUP_CYC - 1 : 0);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC > 0 ? PULSE_CYC - 1 : 0);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [W-1:0] d_nx;
  logic en_nx, busy_nx, done_nx, last;
  assign last = cnt == '0;
  assign ready_out = state == IDLE;
  always_ff @(posedge Clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      D      <= '0;
      enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      D      <= d_nx;
      enable <= en_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = valid_in ? (SETUP_CYC > 0 ? SETUP : PULSE) : IDLE;
      SETUP:   state_nx = last ? PULSE : SETUP;
      PULSE:   state_nx = last ? (HOLD_CYC > 0 ? HOLD : IDLE) : PULSE;
      HOLD:    state_nx = last ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
    // Staying in a timed state always means cnt > 0, so the decrement never wraps.
    cnt_nx = state_nx == state ? (state == IDLE ? '0 : cnt - 4'd1)
           : state_nx == SETUP ? SETUP_LD
           : state_nx == PULSE ? PULSE_LD
           : state_nx == HOLD  ? HOLD_LD : '0;
  end
  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    d_nx    = (state == IDLE && valid_in) ? data_in : D;
    en_nx   = state_nx == PULSE;
    busy_nx = state_nx != IDLE;
    done_nx = state != IDLE && state_nx == IDLE;
  end
endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb_latch_write_sequencer: directed checks of the default and zero-window sequencers
module tb_latch_write_sequencer;
  logic Clk, reset;
  logic [7:0] data_a, data_b, d_a, d_b;
  logic valid_a, valid_b, rdy_a, rdy_b, en_a, en_b, busy_a, busy_b, done_a, done_b;
  int checks = 0;
  int errors = 0;
  latch_write_sequencer #(.W(8)) dut_a (
    .Clk(Clk), .reset(reset), .data_in(data_a), .valid_in(valid_a), .ready_out(rdy_a),
    .D(d_a), .enable(en_a), .busy(busy_a), .done(done_a)
  );
  latch_write_sequencer #(.W(8), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) dut_b (
    .Clk(Clk), .reset(reset), .data_in(data_b), .valid_in(valid_b), .ready_out(rdy_b),
    .D(d_b), .enable(en_b), .busy(busy_b), .done(done_b)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic expect_a(input string tag, input logic [7:0] d, input logic en, input logic rdy,
                          input logic bsy, input logic dn);
    check({tag, ".D"}, d_a, d);
    check({tag, ".enable"}, en_a, en);
    check({tag, ".ready"}, rdy_a, rdy);
    check({tag, ".busy"}, busy_a, bsy);
    check({tag, ".done"}, done_a, dn);
  endtask
  task automatic expect_b(input string tag, input logic [7:0] d, input logic en, input logic rdy,
                          input logic bsy, input logic dn);
    check({tag, ".D"}, d_b, d);
    check({tag, ".enable"}, en_b, en);
    check({tag, ".ready"}, rdy_b, rdy);
    check({tag, ".busy"}, busy_b, bsy);
    check({tag, ".done"}, done_b, dn);
  endtask
  initial begin
    reset = 1'b1; valid_a = 1'b1; data_a = 8'hA5; valid_b = 1'b0; data_b = 8'h00;
    repeat (2) begin
      tick();
      expect_a("rst", 8'h00, 0, 1, 0, 0);
    end
    expect_b("rst_b", 8'h00, 0, 1, 0, 0);
    reset = 1'b0; valid_a = 1'b0;
    tick(); expect_a("idle", 8'h00, 0, 1, 0, 0);
    data_a = 8'h3C; valid_a = 1'b1;
    tick(); valid_a = 1'b0;
    expect_a("wr_setup", 8'h3C, 0, 0, 1, 0);
    tick(); expect_a("wr_pulse1", 8'h3C, 1, 0, 1, 0);
    data_a = 8'hFF; valid_a = 1'b1;
    tick(); expect_a("wr_pulse2", 8'h3C, 1, 0, 1, 0);
    tick(); expect_a("wr_hold", 8'h3C, 0, 0, 1, 0);
    tick(); expect_a("wr_done", 8'h3C, 0, 1, 0, 1);
    tick(); expect_a("acc_ff", 8'hFF, 0, 0, 1, 0);
    valid_a = 1'b0;
    repeat (4) tick();
    expect_a("ff_done", 8'hFF, 0, 1, 0, 1);
    tick(); expect_a("ff_idle", 8'hFF, 0, 1, 0, 0);
    data_a = 8'h11; valid_a = 1'b1;
    tick(); expect_a("b2b_acc1", 8'h11, 0, 0, 1, 0);
    tick(); expect_a("b2b_pulse1", 8'h11, 1, 0, 1, 0);
    tick(); expect_a("b2b_pulse2", 8'h11, 1, 0, 1, 0);
    tick(); expect_a("b2b_hold", 8'h11, 0, 0, 1, 0);
    tick(); expect_a("b2b_done", 8'h11, 0, 1, 0, 1);
    data_a = 8'h22;
    tick(); expect_a("b2b_acc2", 8'h22, 0, 0, 1, 0);
    valid_a = 1'b0;
    repeat (4) tick();
    expect_a("b2b_done2", 8'h22, 0, 1, 0, 1);
    tick(); expect_a("b2b_idle", 8'h22, 0, 1, 0, 0);
    data_a = 8'h5A; valid_a = 1'b1;
    tick(); valid_a = 1'b0;
    expect_a("rm_setup", 8'h5A, 0, 0, 1, 0);
    tick(); expect_a("rm_pulse1", 8'h5A, 1, 0, 1, 0);
    tick(); expect_a("rm_pulse2", 8'h5A, 1, 0, 1, 0);
    reset = 1'b1;
    tick(); expect_a("rm_reset", 8'h00, 0, 1, 0, 0);
    reset = 1'b0;
    tick(); expect_a("rm_after1", 8'h00, 0, 1, 0, 0);
    tick(); expect_a("rm_after2", 8'h00, 0, 1, 0, 0);
    data_b = 8'h81; valid_b = 1'b1;
    tick(); valid_b = 1'b0;
    expect_b("z_pulse", 8'h81, 1, 0, 1, 0);
    tick(); expect_b("z_done", 8'h81, 0, 1, 0, 1);
    tick(); expect_b("z_idle", 8'h81, 0, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
